uart_rx_top: RTL and testbench

16550-style UART receiver; the receive-direction counterpart of uart_tx_top, sharing its line-control inputs (pen, eps, sticky_parity, wls) and its 16x-oversample baud_pulse.
- Deserialises the asynchronous rx line into 5–8-bit characters, LSB first.
- Checks parity and the first stop bit, and detects break.
- Emits a one-cycle push strobe with data and status to the RX FIFO / LSR logic.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx_top.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_top.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, word-length codes and parity helpers
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
        return 4'd5 + {2'b00, wls};
    endfunction

    // Returns the parity bit the transmitter should have sent for this character.
    function automatic logic exp_parity(input logic [7:0] data, input logic [3:0] nbits,
                                        input logic eps, input logic sticky);
        logic [7:0] w_mask;
        logic       w_par;
        w_mask = 8'hFF >> (4'd8 - nbits);
        if (sticky)
            w_par = ~eps;
        else if (eps)
            w_par = ^(data & w_mask);
        else
            w_par = ~^(data & w_mask);
        return w_par;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-flop synchroniser for the rx line, resets to idle-high
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_top.sv
// rtl/uart_rx_top.sv - 16550-style UART receiver: deserialise, parity/framing check, break detect
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic [1:0] wls,
    output logic       push,
    output logic [7:0] dout,
    output logic       pe,
    output logic       fe,
    output logic       bi
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(OVERSAMPLE - 1);

    rx_state_t        r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_bitcnt, w_bitcnt_next;
    logic             w_rx_s, r_rx_prev;
    logic             w_latch_cfg, w_shift_en, w_par_en, w_stop_en;
    logic [7:0]       r_shift;
    logic [3:0]       r_nbits;
    logic             r_pen, r_eps, r_sticky, r_par_bit, r_pe_pend;
    logic             r_push, r_pe, r_fe, r_bi;
    logic [7:0]       r_dout;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_bitcnt <= w_bitcnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_bitcnt_next = r_bitcnt;
        w_latch_cfg   = 1'b0;
        w_shift_en    = 1'b0;
        w_par_en      = 1'b0;
        w_stop_en     = 1'b0;
        if (baud_pulse) begin
            unique case (r_state)
                IDLE: begin
                    // Edge-qualified so a held-low break line cannot retrigger.
                    if (r_rx_prev && !w_rx_s) begin
                        w_cnt_next   = '0;
                        w_state_next = START;
                    end
                end
                START: begin
                    if (r_cnt == CNT_MID) begin
                        if (w_rx_s) begin
                            w_state_next = IDLE;
                        end else begin
                            w_cnt_next    = '0;
                            w_bitcnt_next = '0;
                            w_latch_cfg   = 1'b1;
                            w_state_next  = DATA;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_END) begin
                        w_cnt_next    = '0;
                        w_bitcnt_next = r_bitcnt + 3'd1;
                        w_shift_en    = 1'b1;
                        if ({1'b0, r_bitcnt} == r_nbits - 4'd1)
                            w_state_next = r_pen ? PARITY : STOP;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (r_cnt == CNT_END) begin
                        w_cnt_next   = '0;
                        w_par_en     = 1'b1;
                        w_state_next = STOP;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == CNT_END) begin
                        w_cnt_next   = '0;
                        w_stop_en    = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
            r_shift   <= '0;
            r_nbits   <= 4'd8;
            r_pen     <= 1'b0;
            r_eps     <= 1'b0;
            r_sticky  <= 1'b0;
            r_par_bit <= 1'b0;
            r_pe_pend <= 1'b0;
            r_push    <= 1'b0;
            r_dout    <= '0;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
            r_bi      <= 1'b0;
        end else begin
            r_push <= w_stop_en;
            if (baud_pulse)
                r_rx_prev <= w_rx_s;
            // Line control is frozen for the frame once the start bit is verified.
            if (w_latch_cfg) begin
                r_nbits   <= wls_to_bits(wls);
                r_pen     <= pen;
                r_eps     <= eps;
                r_sticky  <= sticky_parity;
                r_shift   <= '0;
                r_par_bit <= 1'b0;
                r_pe_pend <= 1'b0;
            end
            if (w_shift_en)
                r_shift[r_bitcnt] <= w_rx_s;
            if (w_par_en) begin
                r_par_bit <= w_rx_s;
                r_pe_pend <= w_rx_s != exp_parity(r_shift, r_nbits, r_eps, r_sticky);
            end
            if (w_stop_en) begin
                r_dout <= r_shift;
                r_pe   <= r_pe_pend;
                r_fe   <= ~w_rx_s;
                r_bi   <= (r_shift == 8'h00) && !r_par_bit && !w_rx_s;
            end
        end
    end

    assign push = r_push;
    assign dout = r_dout;
    assign pe   = r_pe;
    assign fe   = r_fe;
    assign bi   = r_bi;

endmodule

// File: tb/tb_uart_rx_top.sv
// tb/tb_uart_rx_top.sv - directed self-checking bench for uart_rx_top
`timescale 1ns/1ps
module tb_uart_rx_top;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b0;
    logic       rx = 1'b1;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       push;
    logic [7:0] dout;
    logic       pe, fe, bi;

    int n_pass = 0;
    int n_total = 0;
    int push_cnt = 0;
    int bp_div = 0;

    uart_rx_top #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .rx            (rx),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .wls           (wls),
        .push          (push),
        .dout          (dout),
        .pe            (pe),
        .fe            (fe),
        .bi            (bi)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            bp_div = 0;
            baud_pulse = 1'b0;
        end else begin
            baud_pulse = (bp_div == 5);
            bp_div = (bp_div == 5) ? 0 : bp_div + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (push === 1'b1) push_cnt++;
    end

    task automatic wait_ticks(input int n);
        repeat (n * 6) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic use_par,
                              input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (use_par) send_bit(par);
        send_bit(stop);
        rx = 1'b1;
        wait_ticks(32);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (push !== 1'b0) $display("FAIL reset_push: got %b expected 0", push); else n_pass++;
        n_total++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else n_pass++;
        n_total++; if ({pe, fe, bi} !== 3'b000) $display("FAIL reset_status: got %b expected 000", {pe, fe, bi}); else n_pass++;
    endtask

    task automatic test_8bit_even();
        int base;
        wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
        base = push_cnt;
        send_frame(8'h13, 8, 1'b1, 1'b1, 1'b1);
        n_total++; if (push_cnt - base != 1) $display("FAIL even_pushes: got %0d expected 1", push_cnt - base); else n_pass++;
        n_total++; if (dout !== 8'h13) $display("FAIL even_dout: got %h expected 13", dout); else n_pass++;
        n_total++; if ({pe, fe, bi} !== 3'b000) $display("FAIL even_status: got %b expected 000", {pe, fe, bi}); else n_pass++;
    endtask

    task automatic test_parity();
        int base;
        base = push_cnt;
        send_frame(8'h13, 8, 1'b1, 1'b0, 1'b1);
        n_total++; if (push_cnt - base != 1) $display("FAIL bad_par_pushes: got %0d expected 1", push_cnt - base); else n_pass++;
        n_total++; if (dout !== 8'h13) $display("FAIL bad_par_dout: got %h expected 13", dout); else n_pass++;
        n_total++; if (pe !== 1'b1) $display("FAIL bad_par_pe: got %b expected 1", pe); else n_pass++;
        sticky_parity = 1'b1; eps = 1'b1;
        send_frame(8'h13, 8, 1'b1, 1'b0, 1'b1);
        n_total++; if (pe !== 1'b0) $display("FAIL sticky0_pe: got %b expected 0", pe); else n_pass++;
        send_frame(8'h13, 8, 1'b1, 1'b1, 1'b1);
        n_total++; if (pe !== 1'b1) $display("FAIL sticky1_pe: got %b expected 1", pe); else n_pass++;
        sticky_parity = 1'b0;
    endtask

    task automatic test_5bit();
        int base;
        wls = 2'b00; pen = 1'b0;
        base = push_cnt;
        send_frame(8'h0D, 5, 1'b0, 1'b0, 1'b1);
        n_total++; if (push_cnt - base != 1) $display("FAIL five_pushes: got %0d expected 1", push_cnt - base); else n_pass++;
        n_total++; if (dout !== 8'h0D) $display("FAIL five_dout: got %h expected 0d", dout); else n_pass++;
        n_total++; if (pe !== 1'b0) $display("FAIL five_pe: got %b expected 0", pe); else n_pass++;
    endtask

    task automatic test_break();
        int base;
        wls = 2'b11; pen = 1'b0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0);
        n_total++; if (dout !== 8'hA5) $display("FAIL fe_dout: got %h expected a5", dout); else n_pass++;
        n_total++; if ({fe, bi} !== 2'b10) $display("FAIL fe_status: got fe,bi=%b expected 10", {fe, bi}); else n_pass++;
        base = push_cnt;
        rx = 1'b0;
        wait_ticks(16 * 30);
        n_total++; if (push_cnt - base != 1) $display("FAIL brk_pushes: got %0d expected 1", push_cnt - base); else n_pass++;
        n_total++; if (dout !== 8'h00) $display("FAIL brk_dout: got %h expected 00", dout); else n_pass++;
        n_total++; if ({fe, bi} !== 2'b11) $display("FAIL brk_status: got fe,bi=%b expected 11", {fe, bi}); else n_pass++;
        rx = 1'b1;
        wait_ticks(48);
        n_total++; if (push_cnt - base != 1) $display("FAIL brk_release_pushes: got %0d expected 1", push_cnt - base); else n_pass++;
    endtask

    task automatic test_glitch();
        int base;
        base = push_cnt;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(32);
        n_total++; if (push_cnt != base) $display("FAIL glitch_pushes: got %0d expected 0", push_cnt - base); else n_pass++;
        n_total++; if (dut.r_state !== IDLE) $display("FAIL glitch_state: got %0d expected %0d", dut.r_state, IDLE); else n_pass++;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        n_total++; if (push_cnt - base != 1) $display("FAIL after_glitch_pushes: got %0d expected 1", push_cnt - base); else n_pass++;
        n_total++; if (dout !== 8'h55) $display("FAIL after_glitch_dout: got %h expected 55", dout); else n_pass++;
        n_total++; if ({fe, bi} !== 2'b00) $display("FAIL after_glitch_status: got fe,bi=%b expected 00", {fe, bi}); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int base;
        logic [7:0] d;
        wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
        d = 8'h13;
        base = push_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        wait_ticks(8);
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (push !== 1'b0) $display("FAIL midrst_push: got %b expected 0", push); else n_pass++;
        n_total++; if (dout !== 8'h00) $display("FAIL midrst_dout: got %h expected 00", dout); else n_pass++;
        n_total++; if ({pe, fe, bi} !== 3'b000) $display("FAIL midrst_status: got %b expected 000", {pe, fe, bi}); else n_pass++;
        wait_ticks(16 * 10);
        n_total++; if (push_cnt != base) $display("FAIL midrst_pushes: got %0d expected 0", push_cnt - base); else n_pass++;
        send_frame(8'h13, 8, 1'b1, 1'b1, 1'b1);
        n_total++; if (push_cnt - base != 1) $display("FAIL post_rst_pushes: got %0d expected 1", push_cnt - base); else n_pass++;
        n_total++; if (dout !== 8'h13) $display("FAIL post_rst_dout: got %h expected 13", dout); else n_pass++;
        n_total++; if (pe !== 1'b0) $display("FAIL post_rst_pe: got %b expected 0", pe); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_8bit_even();
        test_parity();
        test_5bit();
        test_break();
        test_glitch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
